instr_cycle_sequencer: RTL and testbench

Control-pulse sequencer for the instruction-cycle datapath of the three-address machine: 12-bit start/select registers, 31-bit A/B/C registers, 6-bit operator. It steps through the eight-pulse instruction cycle: fetch at `start`, decode, read operand at addr1 into A, read operand at addr2 into B, operate. It emits one-cycle datapath strobes and request pulses, and waits on the memory and arithmetic-unit replies. It sits between the front-panel run/step controls and the datapath register-transfer logic.

---
 rtl/instr_cycle_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_instr_cycle_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/instr_cycle_sequencer.sv
// Instruction-cycle control sequencer: walks fetch/decode/operand/execute pulses,
// issues one-cycle datapath strobes and waits on memory / arithmetic-unit replies.
module instr_cycle_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       step,
  input  logic       fault_clear,
  input  logic       mem_reply,
  input  logic       operate_reply,
  output logic [2:0] pulse,
  output logic       do_pulse,
  output logic       do_start_to_select,
  output logic       do_addr1_to_select,
  output logic       do_addr2_to_select,
  output logic       do_start_inc,
  output logic       do_c_to_operator,
  output logic       do_mem_to_c,
  output logic       do_move_c_to_a,
  output logic       do_move_c_to_b,
  output logic       mem_read_pulse,
  output logic       operate_pulse,
  output logic       busy,
  output logic       instr_done,
  output logic       fault
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [4:0] {
    IDLE, FETCH_SEL, FETCH_RD, FETCH_WAIT, FETCH_LOAD, DECODE,
    OP1_RD, OP1_WAIT, OP1_LOAD, MOVE_A, OP2_RD, OP2_WAIT, OP2_LOAD,
    MOVE_B, EXEC, EXEC_WAIT, FAULT
  } state_e;

  typedef struct packed {
    logic do_pulse;
    logic start_to_select;
    logic addr1_to_select;
    logic addr2_to_select;
    logic start_inc;
    logic c_to_operator;
    logic mem_to_c;
    logic move_c_to_a;
    logic move_c_to_b;
    logic mem_read;
    logic operate;
  } strobe_t;

  state_e          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic            single_q, single_d;
  strobe_t         strobe_q, strobe_d;
  logic [2:0]      pulse_q, pulse_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            fault_q, fault_d;
  logic            is_wait, reply;

  // NOTE: every flop is updated with <= so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      single_q <= 1'b0;
      strobe_q <= '0;
      pulse_q  <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      single_q <= single_d;
      strobe_q <= strobe_d;
      pulse_q  <= pulse_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
    end
  end

  // Each wait state listens only to its own reply line.
  assign is_wait = (state_q == FETCH_WAIT) || (state_q == OP1_WAIT) ||
                   (state_q == OP2_WAIT)   || (state_q == EXEC_WAIT);
  assign reply   = (state_q == EXEC_WAIT) ? operate_reply : mem_reply;

  // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    single_d = single_q;
    if (is_wait && !reply) begin
      if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) state_d = FAULT;
      else                                  cnt_d   = cnt_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (run) begin
          state_d  = FETCH_SEL;
          single_d = 1'b0;
        end else if (step) begin
          state_d  = FETCH_SEL;
          single_d = 1'b1;
        end
      end
      FETCH_SEL:  state_d = FETCH_RD;
      FETCH_RD:   state_d = FETCH_WAIT;
      FETCH_WAIT: if (reply) state_d = FETCH_LOAD;
      FETCH_LOAD: state_d = DECODE;
      DECODE:     state_d = OP1_RD;
      OP1_RD:     state_d = OP1_WAIT;
      OP1_WAIT:   if (reply) state_d = OP1_LOAD;
      OP1_LOAD:   state_d = MOVE_A;
      MOVE_A:     state_d = OP2_RD;
      OP2_RD:     state_d = OP2_WAIT;
      OP2_WAIT:   if (reply) state_d = OP2_LOAD;
      OP2_LOAD:   state_d = MOVE_B;
      MOVE_B:     state_d = EXEC;
      EXEC:       state_d = EXEC_WAIT;
      EXEC_WAIT: begin
        if (reply) begin
          if (run && !single_q) begin
            state_d = FETCH_SEL;
          end else begin
            state_d  = IDLE;
            single_d = 1'b0;
          end
        end
      end
      FAULT:      if (fault_clear) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    strobe_d = '0;
    pulse_d  = pulse_q;
    busy_d   = (state_d != IDLE) && (state_d != FAULT);
    fault_d  = (state_d == FAULT);
    done_d   = (state_q == EXEC_WAIT) && operate_reply;
    case (state_d)
      FETCH_SEL:  begin pulse_d = 3'd0; strobe_d.do_pulse = 1'b1; strobe_d.start_to_select = 1'b1; end
      FETCH_RD:   begin pulse_d = 3'd1; strobe_d.do_pulse = 1'b1; strobe_d.mem_read = 1'b1; end
      FETCH_WAIT: pulse_d = 3'd2;
      FETCH_LOAD: strobe_d.mem_to_c = 1'b1;
      DECODE: begin
        strobe_d.do_pulse        = 1'b1;
        strobe_d.addr1_to_select = 1'b1;
        strobe_d.start_inc       = 1'b1;
        strobe_d.c_to_operator   = 1'b1;
      end
      OP1_RD:     begin pulse_d = 3'd3; strobe_d.do_pulse = 1'b1; strobe_d.mem_read = 1'b1; end
      OP1_WAIT:   pulse_d = 3'd4;
      OP1_LOAD:   begin strobe_d.mem_to_c = 1'b1; strobe_d.addr2_to_select = 1'b1; end
      MOVE_A:     begin strobe_d.do_pulse = 1'b1; strobe_d.move_c_to_a = 1'b1; end
      OP2_RD:     begin pulse_d = 3'd5; strobe_d.do_pulse = 1'b1; strobe_d.mem_read = 1'b1; end
      OP2_WAIT:   pulse_d = 3'd6;
      OP2_LOAD:   strobe_d.mem_to_c = 1'b1;
      MOVE_B:     begin strobe_d.do_pulse = 1'b1; strobe_d.move_c_to_b = 1'b1; end
      EXEC:       begin pulse_d = 3'd7; strobe_d.do_pulse = 1'b1; strobe_d.operate = 1'b1; end
      EXEC_WAIT:  pulse_d = 3'd0;
      default:    ;
    endcase
  end

  assign pulse              = pulse_q;
  assign do_pulse           = strobe_q.do_pulse;
  assign do_start_to_select = strobe_q.start_to_select;
  assign do_addr1_to_select = strobe_q.addr1_to_select;
  assign do_addr2_to_select = strobe_q.addr2_to_select;
  assign do_start_inc       = strobe_q.start_inc;
  assign do_c_to_operator   = strobe_q.c_to_operator;
  assign do_mem_to_c        = strobe_q.mem_to_c;
  assign do_move_c_to_a     = strobe_q.move_c_to_a;
  assign do_move_c_to_b     = strobe_q.move_c_to_b;
  assign mem_read_pulse     = strobe_q.mem_read;
  assign operate_pulse      = strobe_q.operate;
  assign busy               = busy_q;
  assign instr_done         = done_q;
  assign fault              = fault_q;

endmodule

// File: tb/tb_instr_cycle_sequencer.sv
// Bench for instr_cycle_sequencer: a table-driven instruction-cycle model is stepped
// alongside the DUT under directed and randomized run/step/reply/reset stimulus.
module tb_instr_cycle_sequencer;

  localparam int TO = 8;

  // Expected/observed vector layout
  localparam logic [16:0] DP   = 17'd1 << 3;
  localparam logic [16:0] STS  = 17'd1 << 4;
  localparam logic [16:0] A1S  = 17'd1 << 5;
  localparam logic [16:0] A2S  = 17'd1 << 6;
  localparam logic [16:0] SINC = 17'd1 << 7;
  localparam logic [16:0] C2O  = 17'd1 << 8;
  localparam logic [16:0] M2C  = 17'd1 << 9;
  localparam logic [16:0] MVA  = 17'd1 << 10;
  localparam logic [16:0] MVB  = 17'd1 << 11;
  localparam logic [16:0] MRD  = 17'd1 << 12;
  localparam logic [16:0] OPP  = 17'd1 << 13;
  localparam logic [16:0] BSY  = 17'd1 << 14;
  localparam logic [16:0] DONE = 17'd1 << 15;
  localparam logic [16:0] FLT  = 17'd1 << 16;

  logic clk = 1'b0;
  logic rst, run, step, fault_clear, mem_reply, operate_reply;
  logic [2:0] pulse;
  logic do_pulse, do_start_to_select, do_addr1_to_select, do_addr2_to_select;
  logic do_start_inc, do_c_to_operator, do_mem_to_c, do_move_c_to_a, do_move_c_to_b;
  logic mem_read_pulse, operate_pulse, busy, instr_done, fault;

  always #5 clk = ~clk;

  instr_cycle_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .fault_clear(fault_clear),
    .mem_reply(mem_reply), .operate_reply(operate_reply), .pulse(pulse),
    .do_pulse(do_pulse), .do_start_to_select(do_start_to_select),
    .do_addr1_to_select(do_addr1_to_select), .do_addr2_to_select(do_addr2_to_select),
    .do_start_inc(do_start_inc), .do_c_to_operator(do_c_to_operator),
    .do_mem_to_c(do_mem_to_c), .do_move_c_to_a(do_move_c_to_a),
    .do_move_c_to_b(do_move_c_to_b), .mem_read_pulse(mem_read_pulse),
    .operate_pulse(operate_pulse), .busy(busy), .instr_done(instr_done), .fault(fault)
  );

  // Instruction-cycle table: strobes, pulse number (-1 = hold), wait kind (1 mem, 2 operate)
  logic [16:0] tbl_strobe [15];
  int          tbl_pulse  [15];
  int          tbl_wait   [15];

  // Model: m_pos -1 idle, -2 fault, 0..14 position in the table
  int         m_pos = -1;
  int         m_wait = 0;
  bit         m_single = 1'b0;
  logic [2:0] m_pulse = 3'd0;
  bit         m_done = 1'b0;
  int         target = 1;
  bit         hold_rst = 1'b0;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic set_row(input int i, input logic [16:0] s, input int p, input int w);
    tbl_strobe[i] = s;
    tbl_pulse[i]  = p;
    tbl_wait[i]   = w;
  endtask

  task automatic init_table();
    set_row(0,  DP | STS,              0, 0);
    set_row(1,  DP | MRD,              1, 0);
    set_row(2,  '0,                    2, 1);
    set_row(3,  M2C,                  -1, 0);
    set_row(4,  DP | A1S | SINC | C2O, -1, 0);
    set_row(5,  DP | MRD,              3, 0);
    set_row(6,  '0,                    4, 1);
    set_row(7,  M2C | A2S,            -1, 0);
    set_row(8,  DP | MVA,             -1, 0);
    set_row(9,  DP | MRD,              5, 0);
    set_row(10, '0,                    6, 1);
    set_row(11, M2C,                  -1, 0);
    set_row(12, DP | MVB,             -1, 0);
    set_row(13, DP | OPP,              7, 0);
    set_row(14, '0,                    0, 2);
  endtask

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] model_out();
    logic [16:0] v;
    v = '0;
    v[2:0] = m_pulse;
    if (m_pos >= 0)  v = v | tbl_strobe[m_pos] | BSY;
    if (m_pos == -2) v = v | FLT;
    if (m_done)      v = v | DONE;
    return v;
  endfunction

  task automatic model_step();
    int nxt;
    bit rep;
    nxt = m_pos;
    m_done = 1'b0;
    if (rst) begin
      m_pos = -1; m_wait = 0; m_single = 1'b0; m_pulse = 3'd0;
      return;
    end
    if (m_pos == -1) begin
      if (run)       begin nxt = 0; m_single = 1'b0; end
      else if (step) begin nxt = 0; m_single = 1'b1; end
    end else if (m_pos == -2) begin
      if (fault_clear) nxt = -1;
    end else if (tbl_wait[m_pos] != 0) begin
      rep = (tbl_wait[m_pos] == 1) ? mem_reply : operate_reply;
      if (rep) begin
        if (m_pos == 14) begin
          m_done = 1'b1;
          nxt = (run && !m_single) ? 0 : -1;
        end else begin
          nxt = m_pos + 1;
        end
      end else begin
        m_wait++;
        if (m_wait == TO) nxt = -2;
      end
    end else begin
      nxt = m_pos + 1;
    end
    if (nxt != m_pos) begin
      m_wait = 0;
      if (nxt >= 0 && tbl_pulse[nxt] >= 0) m_pulse = 3'(tbl_pulse[nxt]);
    end
    m_pos = nxt;
  endtask

  // Inputs for the coming edge, chosen from where the model says the DUT is.
  task automatic drive(input bit rnd);
    int  wk;
    bit  fire;
    wk = (m_pos >= 0) ? tbl_wait[m_pos] : 0;
    if (wk != 0 && m_wait == 0) begin
      if (!rnd)                            target = 3;
      else if ($urandom_range(0, 14) == 0) target = TO + 1;
      else if ($urandom_range(0, 9) == 0)  target = TO;
      else                                 target = int'($urandom_range(1, 4));
    end
    fire = (wk != 0) && (m_wait + 1 == target);
    rst = hold_rst; step = 1'b0; fault_clear = 1'b0;
    mem_reply = (wk == 1) && fire;
    operate_reply = (wk == 2) && fire;
    if (!rnd) begin
      run = 1'b1;
      return;
    end
    if ($urandom_range(0, 29) == 0) run = ~run;
    step = ($urandom_range(0, 9) == 0);
    fault_clear = (m_pos == -2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
    if (wk != 1 && $urandom_range(0, 3) == 0) mem_reply = 1'b1;
    if (wk != 2 && $urandom_range(0, 3) == 0) operate_reply = 1'b1;
    if ($urandom_range(0, 199) == 0 || (m_pos == 10 && $urandom_range(0, 7) == 0)) rst = 1'b1;
  endtask

  task automatic cycle(input bit rnd);
    @(negedge clk);
    drive(rnd);
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check($sformatf("cyc%0d pos%0d", cyc, m_pos),
          {fault, instr_done, busy, operate_pulse, mem_read_pulse, do_move_c_to_b,
           do_move_c_to_a, do_mem_to_c, do_c_to_operator, do_start_inc,
           do_addr2_to_select, do_addr1_to_select, do_start_to_select, do_pulse, pulse},
          model_out());
  endtask

  initial begin
    init_table();
    rst = 1'b1; run = 1'b0; step = 1'b0; fault_clear = 1'b0;
    mem_reply = 1'b0; operate_reply = 1'b0;
    hold_rst = 1'b1;
    repeat (2) cycle(1'b0);
    hold_rst = 1'b0;
    // Continuous run, every reply in the third wait cycle: 23 cycles per instruction
    repeat (75) cycle(1'b0);
    // Randomized run/step/fault_clear/replies/reset, strays included
    repeat (5000) cycle(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
